// File: rtl/ibus_rom_bridge.sv
// Instruction-bus slave for the asynchronous-read program ROM: inserts wait states,
// registers fetched data and flags ibus protocol violations with sticky error state.
module ibus_rom_bridge #(
  parameter int unsigned WAIT_CYCLE     = 0,
  parameter int unsigned ROM_ADDR_WIDTH = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ibus_address,
  input  logic        ibus_read,
  input  logic        ibus_write,
  input  logic [3:0]  ibus_byteenable,
  input  logic [31:0] ibus_wrdata,
  output logic [31:0] ibus_rddata,
  output logic        ibus_stall,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  output logic        proto_error,
  output logic [1:0]  err_code
);

  if (WAIT_CYCLE > 255) begin : g_wait_cycle_range
    $error("ibus_rom_bridge: WAIT_CYCLE must be in 0..255");
  end

  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLE);
  localparam logic [31:0] ROM_MASK  = (ROM_ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << ROM_ADDR_WIDTH) - 32'd1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t      state, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rddata_d;
  logic [7:0]  cnt, cnt_d;
  logic        err_set;
  logic [1:0]  err_val;

  // Reads are always full word; these inputs exist only for bus compatibility.
  logic unused_inputs;
  assign unused_inputs = ^{ibus_byteenable, ibus_wrdata};

  assign ibus_stall  = (ibus_read | ibus_write) & (state != DONE);
  assign rom_address = addr_q & ROM_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      cnt         <= '0;
      ibus_rddata <= '0;
      proto_error <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      state       <= state_d;
      addr_q      <= addr_d;
      cnt         <= cnt_d;
      ibus_rddata <= rddata_d;
      proto_error <= proto_error | err_set;
      if (err_set && (err_code == 2'b00)) begin
        err_code <= err_val;
      end
    end
  end

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    cnt_d    = cnt;
    rddata_d = ibus_rddata;
    err_set  = 1'b0;
    err_val  = 2'b00;
    case (state)
      IDLE: begin
        if (ibus_read) begin
          addr_d  = ibus_address;
          cnt_d   = WAIT_INIT;
          state_d = FETCH;
          if (ibus_write) begin
            err_set = 1'b1;
            err_val = 2'b11;
          end
        end else if (ibus_write) begin
          err_set = 1'b1;
          err_val = 2'b11;
          state_d = DONE;
        end
      end
      FETCH: begin
        // A dropped read outranks an address change.
        if (!ibus_read) begin
          err_set = 1'b1;
          err_val = 2'b10;
          state_d = IDLE;
        end else if (ibus_address != addr_q) begin
          err_set = 1'b1;
          err_val = 2'b01;
          addr_d  = ibus_address;
          cnt_d   = WAIT_INIT;
        end else if (cnt != '0) begin
          cnt_d = cnt - 8'd1;
        end else begin
          rddata_d = rom_data;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ibus_rom_bridge.sv
// Directed bench for ibus_rom_bridge: four instances with different wait-state counts
// share the bus stimulus; each scenario checks the instance it targets.
module tb_ibus_rom_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic        ibus_write;
  logic [3:0]  ibus_byteenable;
  logic [31:0] ibus_wrdata;

  logic [31:0] rddata_o   [4];
  logic        stall_o    [4];
  logic [31:0] rom_addr_o [4];
  logic [31:0] rom_data_i [4];
  logic        perr_o     [4];
  logic [1:0]  ecode_o    [4];

  logic [31:0] rom [0:2047];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned WV = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 5;
    assign rom_data_i[g] = rom[rom_addr_o[g][12:2]];
    ibus_rom_bridge #(.WAIT_CYCLE(WV), .ROM_ADDR_WIDTH(13)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .ibus_address    (ibus_address),
      .ibus_read       (ibus_read),
      .ibus_write      (ibus_write),
      .ibus_byteenable (ibus_byteenable),
      .ibus_wrdata     (ibus_wrdata),
      .ibus_rddata     (rddata_o[g]),
      .ibus_stall      (stall_o[g]),
      .rom_address     (rom_addr_o[g]),
      .rom_data        (rom_data_i[g]),
      .proto_error     (perr_o[g]),
      .err_code        (ecode_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        exp_stall;
    logic [31:0] exp_data;
    logic [31:0] exp_rom;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Leaves the bench at the drive point (1 time unit after a posedge) with the DUTs idle.
  task automatic do_reset();
    ibus_read    = 1'b0;
    ibus_write   = 1'b0;
    ibus_address = '0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues a read at the drive point, counts stall-high cycles, checks data in the release cycle.
  task automatic run_read(input int idx, input logic [31:0] addr, input int exp_high,
                          input logic [31:0] exp_data, input string name);
    int n;
    n            = 0;
    ibus_read    = 1'b1;
    ibus_address = addr;
    @(negedge clk);
    while (stall_o[idx] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_high));
    chk({name, "_rddata"}, rddata_o[idx], exp_data);
    @(posedge clk); #1;
  endtask

  initial begin
    ibus_byteenable = 4'hF;
    ibus_wrdata     = 32'hDEAD_BEEF;
    for (int i = 0; i < 2048; i++) rom[i] = 32'h5A00_0000 | 32'(i);
    rom[0] = 32'h3C01_0001;
    rom[1] = 32'h2421_0005;
    rom[2] = 32'h0022_1820;
    rom[4] = 32'h8C03_0010;
    rom[8] = 32'hAC03_0020;

    // WAIT_CYCLE=0 cycle-by-cycle: two reads, a hold cycle, then an aliased address.
    vecs[0]  = '{1'b1, 32'h8000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h8000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'h8000_0000, 1'b0, 32'h3C01_0001, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h8000_0000, 1'b0, 32'h3C01_0001, 32'h0000_0000};
    vecs[4]  = '{1'b1, 32'h8000_0004, 1'b1, 32'h3C01_0001, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h8000_0004, 1'b1, 32'h3C01_0001, 32'h0000_0004};
    vecs[6]  = '{1'b1, 32'h8000_0004, 1'b0, 32'h2421_0005, 32'h0000_0004};
    vecs[7]  = '{1'b1, 32'h8000_2000, 1'b1, 32'h2421_0005, 32'h0000_0004};
    vecs[8]  = '{1'b1, 32'h8000_2000, 1'b1, 32'h2421_0005, 32'h0000_0000};
    vecs[9]  = '{1'b1, 32'h8000_2000, 1'b0, 32'h3C01_0001, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h8000_2000, 1'b0, 32'h3C01_0001, 32'h0000_0000};

    rst          = 1'b1;
    ibus_read    = 1'b0;
    ibus_write   = 1'b0;
    ibus_address = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    @(negedge clk);
    chk("reset_rddata", rddata_o[0], 32'h0);
    chk("reset_stall", 32'(stall_o[0]), 32'h0);
    chk("reset_perr", 32'(perr_o[0]), 32'h0);
    chk("reset_ecode", 32'(ecode_o[0]), 32'h0);
    chk("reset_rom_addr", rom_addr_o[0], 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      ibus_read    = vecs[i].rd;
      ibus_address = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall_o[0]), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_rddata", i), rddata_o[0], vecs[i].exp_data);
      chk($sformatf("vec%0d_rom_addr", i), rom_addr_o[0], vecs[i].exp_rom);
      chk($sformatf("vec%0d_perr", i), 32'(perr_o[0]), 32'h0);
      @(posedge clk); #1;
    end

    // WAIT_CYCLE=3: full-latency read followed by a back-to-back read.
    do_reset();
    run_read(1, 32'h8000_0004, 5, 32'h2421_0005, "w3_read1");
    run_read(1, 32'h8000_0008, 5, 32'h0022_1820, "w3_b2b");
    ibus_read = 1'b0;
    @(negedge clk);
    chk("w3_no_error", 32'(perr_o[1]), 32'h0);
    @(posedge clk); #1;

    // WAIT_CYCLE=3: read dropped in the second FETCH cycle.
    do_reset();
    run_read(1, 32'h8000_0004, 5, 32'h2421_0005, "drop_pre");
    ibus_read = 1'b0;
    @(posedge clk); #1;
    ibus_read    = 1'b1;
    ibus_address = 32'h8000_0008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ibus_read = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_rddata_kept", rddata_o[1], 32'h2421_0005);
    chk("drop_perr", 32'(perr_o[1]), 32'h1);
    chk("drop_ecode", 32'(ecode_o[1]), 32'h2);
    @(posedge clk); #1;
    run_read(1, 32'h8000_0008, 5, 32'h0022_1820, "drop_then_idle");

    // WAIT_CYCLE=2: address change mid-FETCH restarts the fetch.
    begin
      int n;
      do_reset();
      ibus_read    = 1'b1;
      ibus_address = 32'h8000_0010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ibus_address = 32'h8000_0020;
      n = 0;
      @(negedge clk);
      while (stall_o[2] && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("addr_chg_latency", 32'(n), 32'd4);
      chk("addr_chg_rddata", rddata_o[2], 32'hAC03_0020);
      chk("addr_chg_ecode", 32'(ecode_o[2]), 32'h1);
      chk("addr_chg_perr", 32'(perr_o[2]), 32'h1);
      @(posedge clk); #1;
      ibus_address = 32'h8000_0010;
      @(posedge clk); #1;
      ibus_read = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("first_error_wins", 32'(ecode_o[2]), 32'h1);
      @(posedge clk); #1;
    end

    // WAIT_CYCLE=0: write to ROM, then simultaneous read+write.
    do_reset();
    ibus_write   = 1'b1;
    ibus_address = 32'h8000_0000;
    @(negedge clk);
    chk("wr_stall_hi", 32'(stall_o[0]), 32'h1);
    @(negedge clk);
    chk("wr_stall_lo", 32'(stall_o[0]), 32'h0);
    chk("wr_rddata_kept", rddata_o[0], 32'h0);
    chk("wr_ecode", 32'(ecode_o[0]), 32'h3);
    chk("wr_perr", 32'(perr_o[0]), 32'h1);
    @(posedge clk); #1;
    ibus_write = 1'b0;
    @(posedge clk); #1;
    do_reset();
    ibus_write = 1'b1;
    run_read(0, 32'h8000_0004, 2, 32'h2421_0005, "rdwr");
    ibus_write = 1'b0;
    @(negedge clk);
    chk("rdwr_ecode", 32'(ecode_o[0]), 32'h3);
    @(posedge clk); #1;

    // WAIT_CYCLE=5: reset asserted mid-FETCH.
    do_reset();
    run_read(3, 32'h8000_0004, 7, 32'h2421_0005, "w5_pre");
    ibus_read  = 1'b0;
    ibus_write = 1'b1;
    @(posedge clk); #1;
    ibus_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("w5_pre_perr", 32'(perr_o[3]), 32'h1);
    @(posedge clk); #1;
    ibus_read    = 1'b1;
    ibus_address = 32'h8000_0008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rddata", rddata_o[3], 32'h0);
    chk("rst_mid_perr", 32'(perr_o[3]), 32'h0);
    chk("rst_mid_ecode", 32'(ecode_o[3]), 32'h0);
    chk("rst_mid_rom_addr", rom_addr_o[3], 32'h0);
    chk("rst_mid_stall_rd", 32'(stall_o[3]), 32'h1);
    ibus_read = 1'b0;
    #1;
    chk("rst_mid_stall_idle", 32'(stall_o[3]), 32'h0);
    @(posedge clk); #1;
    run_read(3, 32'h8000_0008, 7, 32'h0022_1820, "rst_mid_after");
    ibus_read = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibus_rom_bridge.md
Name: ibus_rom_bridge

Overview:
- Instruction-bus slave between the naive_mips ibus master port and the asynchronous-read program ROM (prog_rom).
- Generates ibus_stall and inserts a configurable number of wait states.
- Registers fetched data so ibus_rddata is stable when the stall releases.
- Checks ibus protocol: address stability, premature read drop, writes to ROM. Violations raise sticky error flags for bench and debug use.

Parameters:
WAIT_CYCLE, 0, extra wait states inserted before ROM data is captured (0..255)
ROM_ADDR_WIDTH, 13, number of low byte-address bits forwarded to the ROM; upper bits forced to 0

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
ibus_address  input  32  CPU fetch byte address
ibus_read  input  1  CPU read request, held until stall drops
ibus_write  input  1  CPU write request (illegal to ROM)
ibus_byteenable  input  4  ignored (reads are always full word)
ibus_wrdata  input  32  ignored
ibus_rddata  output  32  registered fetch data
ibus_stall  output  1  high while a request is pending and not complete
rom_address  output  32  {zeros, addr_q[ROM_ADDR_WIDTH-1:0]}
rom_data  input  32  combinational ROM read data for rom_address
proto_error  output  1  sticky: any protocol violation since reset
err_code  output  2  sticky first-error code: 00 none, 01 address changed, 10 read dropped, 11 write attempted

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, addr_q=0, cnt=0, ibus_rddata=0.
  - proto_error=0, err_code=00.
  - Reset mid-transaction aborts it with no data update.
- ibus_stall = (ibus_read|ibus_write) & (state!=DONE). Combinational from state and inputs.
- IDLE:
  - ibus_read: addr_q<=ibus_address, cnt<=WAIT_CYCLE, go FETCH.
  - ibus_write (read low): record error 11, go DONE. ROM unaffected, ibus_rddata unchanged.
  - read and write both high: treated as read, and error 11 recorded.
- FETCH:
  - rom_address driven from addr_q.
  - ibus_read low: record error 10, go IDLE, no data capture. This check has priority over the address check.
  - ibus_address!=addr_q: record error 01, addr_q<=ibus_address, cnt<=WAIT_CYCLE, stay FETCH (restart).
  - Otherwise, cnt!=0: cnt<=cnt-1.
  - Otherwise, cnt==0: ibus_rddata<=rom_data, go DONE.
- DONE:
  - ibus_stall low for exactly one cycle; the CPU consumes ibus_rddata at this posedge.
  - Next state is IDLE unconditionally. A back-to-back request is seen in IDLE the following cycle.
- Latency: for an uninterrupted read, stall is high for WAIT_CYCLE+2 cycles, then low for 1 cycle.
- ibus_rddata holds its value between transactions; it changes only on capture or reset.
- Error recording:
  - proto_error<=1 on any violation.
  - err_code is written only while it is 00 (first error wins).
  - Both are cleared only by rst.
- cnt width is 8 bits. WAIT_CYCLE>255 is illegal; an elaboration-time check must flag it.
- Address bits at or above ROM_ADDR_WIDTH are dropped, so those addresses alias. This is not an error.

Test Plan:
- WAIT_CYCLE=0, ROM[0x000]=0x3C010001, read 0x80000000 -> stall high 2 cycles, low 1; ibus_rddata=0x3C010001; rom_address=0x00000000; proto_error=0.
- WAIT_CYCLE=3, read 0x80000004 with ROM word 1=0x24210005 -> stall high 5 cycles; ibus_rddata=0x24210005 in the stall-low cycle; back-to-back read of 0x80000008 starts the next cycle.
- WAIT_CYCLE=3, drop ibus_read in the 2nd FETCH cycle -> state returns to IDLE, ibus_rddata unchanged, proto_error=1, err_code=10.
- WAIT_CYCLE=2, change address 0x80000010->0x80000020 mid-FETCH -> restart; data from byte 0x020 returned 4 cycles after the change; err_code=01. A later read drop leaves err_code at 01.
- ibus_write=1 to 0x80000000 in IDLE -> stall high 1 cycle then low; ROM contents unchanged; err_code=11.
- Assert rst during FETCH with WAIT_CYCLE=5 -> next cycle state=IDLE, ibus_rddata=0, proto_error=0, stall follows ibus_read from IDLE.
